// File: rtl/pipe_stage_skid.sv
// Registered valid/ready pipeline stage with a one-entry skid buffer; all outputs come from flops.
// Optional PIPE_STAGE_PERF_EN adds saturating stall_cnt / xfer_cnt performance counters.
module pipe_stage_skid #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       xfer_cnt
`endif
);

  // state | meaning
  // EMPTY | no payload held; out_valid=0, in_ready=1
  // ONE   | main holds the head payload; out_valid=1, in_ready=1
  // FULL  | main holds head, skid holds next; out_valid=1, in_ready=0
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              up_xfer;
  logic              dn_xfer;

  assign up_xfer  = in_valid & in_ready;
  assign dn_xfer  = out_valid & out_ready;
  assign out_data = main_q;

  // out_valid / in_ready are kept as their own flops so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (clear) begin
      state     <= EMPTY;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (up_xfer) begin
            main_q    <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ONE: begin
          if (up_xfer && dn_xfer) begin
            main_q <= in_data;
          end else if (up_xfer) begin
            skid_q   <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (dn_xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (dn_xfer) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Counters ignore clear so software can read totals across flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      xfer_cnt  <= 32'd0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (dn_xfer && (xfer_cnt != 32'hFFFF_FFFF)) begin
        xfer_cnt <= xfer_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed streaming/backpressure/clear/reset on a
// 32-bit stage, random traffic on 1-bit and 256-bit stages, counters when PIPE_STAGE_PERF_EN is set.
module tb_pipe_stage_skid;

  localparam logic [31:0]  RV32  = 32'h5A5A_00C3;
  localparam logic         RV1   = 1'b1;
  localparam logic [255:0] RV256 = {8{32'hC0FF_EE01}};

  logic clk;
  logic rst_n;
  logic clear;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] id32, od32;
  logic        iv1, ir1, ov1, or1;
  logic        id1, od1;
  logic         iv256, ir256, ov256, or256;
  logic [255:0] id256, od256;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall32, xfer32, stall1, xfer1, stall256, xfer256;
`endif

  int checks   = 0;
  int failures = 0;

  logic [255:0] sbq [3][$];
  logic         prev_stall [3];
  logic [255:0] prev_data  [3];
  int           pushed     [3];
  int           popped     [3];
  string        nm         [3] = '{"d32", "w1", "w256"};

  pipe_stage_skid #(.DATA_W(32), .RESET_VAL(RV32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(iv32), .in_ready(ir32), .in_data(id32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall32), .xfer_cnt(xfer32)
`endif
  );

  pipe_stage_skid #(.DATA_W(1), .RESET_VAL(RV1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall1), .xfer_cnt(xfer1)
`endif
  );

  pipe_stage_skid #(.DATA_W(256), .RESET_VAL(RV256)) u_w256 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(iv256), .in_ready(ir256), .in_data(id256),
    .out_valid(ov256), .out_ready(or256), .out_data(od256)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall256), .xfer_cnt(xfer256)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Occupancy model: the stage holds exactly the payloads accepted but not yet delivered.
  task automatic sb_step(input int k, input logic ov, input logic ir, input logic [255:0] od,
                         input logic rdy, input logic iv, input logic [255:0] id, input logic clr);
    if (prev_stall[k]) begin
      chk($sformatf("%s_stall_valid", nm[k]), ov, 1'b1);
      chk($sformatf("%s_stall_data", nm[k]), od, prev_data[k]);
    end
    if (clr) begin
      sbq[k].delete();
      prev_stall[k] = 1'b0;
    end else begin
      chk($sformatf("%s_out_valid", nm[k]), ov, sbq[k].size() > 0);
      chk($sformatf("%s_in_ready", nm[k]), ir, sbq[k].size() < 2);
      if (ov && sbq[k].size() > 0) begin
        chk($sformatf("%s_order", nm[k]), od, sbq[k][0]);
        if (rdy) begin
          void'(sbq[k].pop_front());
          popped[k]++;
        end
      end
      if (iv && ir) begin
        sbq[k].push_back(id);
        pushed[k]++;
      end
      prev_stall[k] = ov && !rdy;
      prev_data[k]  = od;
    end
  endtask

  task automatic advance();
    sb_step(0, ov32, ir32, od32, or32, iv32, id32, clear);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    advance();
  endtask

  task automatic drive32(input logic iv, input logic [31:0] d, input logic rdy, input logic clr);
    iv32  = iv;
    id32  = d;
    or32  = rdy;
    clear = clr;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      prev_stall[k] = 1'b0;
      prev_data[k]  = '0;
      pushed[k]     = 0;
      popped[k]     = 0;
    end
    rst_n = 1'b0;
    clear = 1'b0;
    drive32(1'b0, 32'd0, 1'b0, 1'b0);
    iv1 = 1'b0; id1 = 1'b0; or1 = 1'b0;
    iv256 = 1'b0; id256 = '0; or256 = 1'b0;

    #12;
    chk("rst_out_valid", ov32, 1'b0);
    chk("rst_in_ready", ir32, 1'b1);
    chk("rst_out_data", od32, RV32);
    chk("rst_w1_data", od1, RV1);
    chk("rst_w256_data", od256, RV256);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // streaming 1..4 at full rate
    for (int i = 1; i <= 4; i++) begin
      drive32(1'b1, i, 1'b1, 1'b0);
      @(negedge clk);
      if (i > 1) begin
        chk("stream_valid", ov32, 1'b1);
        chk("stream_data", od32, i - 1);
      end
      advance();
    end
    drive32(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("stream_last", od32, 32'd4);
    advance();

    // backpressure: ONE(5), accept 6 while stalled, then drain 5, 6
    drive32(1'b1, 32'd5, 1'b1, 1'b0);
    cyc();
    drive32(1'b1, 32'd6, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_one_data", od32, 32'd5);
    chk("bp_one_ready", ir32, 1'b1);
    advance();
    drive32(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_full_ready", ir32, 1'b0);
    chk("bp_full_data", od32, 32'd5);
    advance();
    drive32(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_drain_first", od32, 32'd5);
    advance();
    @(negedge clk);
    chk("bp_drain_second", od32, 32'd6);
    advance();
    @(negedge clk);
    chk("bp_drained", ov32, 1'b0);
    advance();

    // clear while FULL with 9 presented
    drive32(1'b1, 32'd7, 1'b0, 1'b0);
    cyc();
    drive32(1'b1, 32'd8, 1'b0, 1'b0);
    cyc();
    drive32(1'b1, 32'd9, 1'b0, 1'b1);
    cyc();
    drive32(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("clr_full_valid", ov32, 1'b0);
    chk("clr_full_ready", ir32, 1'b1);
    chk("clr_full_data", od32, RV32);
    advance();
    cyc();

    // clear while ONE with 9 accepted-looking in the same cycle
    drive32(1'b1, 32'd10, 1'b0, 1'b0);
    cyc();
    drive32(1'b1, 32'd9, 1'b1, 1'b1);
    cyc();
    drive32(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("clr_one_valid", ov32, 1'b0);
    chk("clr_one_data", od32, RV32);
    advance();
    cyc();

    // asynchronous reset between edges while FULL
    drive32(1'b1, 32'h21, 1'b0, 1'b0);
    cyc();
    drive32(1'b1, 32'h22, 1'b0, 1'b0);
    cyc();
    drive32(1'b0, 32'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ov32, 1'b0);
    chk("arst_ready", ir32, 1'b1);
    chk("arst_data", od32, RV32);
    sbq[0].delete();
    prev_stall[0] = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc();

`ifdef PIPE_STAGE_PERF_EN
    chk("perf_stall_rst", stall32, 32'd0);
    chk("perf_xfer_rst", xfer32, 32'd0);
    drive32(1'b1, 32'h10, 1'b0, 1'b0);
    cyc();
    drive32(1'b1, 32'h11, 1'b0, 1'b0);
    cyc();
    drive32(1'b0, 32'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    drive32(1'b0, 32'd0, 1'b1, 1'b0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      drive32(1'b1, 32'h12 + i, 1'b1, 1'b0);
      cyc();
    end
    drive32(1'b0, 32'd0, 1'b1, 1'b0);
    cyc();
    @(negedge clk);
    chk("perf_stall", stall32, 32'd3);
    chk("perf_xfer", xfer32, 32'd7);
    advance();
    drive32(1'b0, 32'd0, 1'b1, 1'b1);
    cyc();
    drive32(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("perf_stall_clr", stall32, 32'd3);
    chk("perf_xfer_clr", xfer32, 32'd7);
    advance();
`endif

    // random 50% valid/ready on the narrow and wide stages
    for (int n = 0; n < 10000; n++) begin
      iv1   = 1'($urandom_range(0, 1));
      or1   = 1'($urandom_range(0, 1));
      id1   = 1'($urandom_range(0, 1));
      iv256 = 1'($urandom_range(0, 1));
      or256 = 1'($urandom_range(0, 1));
      for (int j = 0; j < 8; j++) id256[j*32 +: 32] = $urandom;
      @(negedge clk);
      sb_step(1, ov1, ir1, od1, or1, iv1, id1, clear);
      sb_step(2, ov256, ir256, od256, or256, iv256, id256, clear);
      @(posedge clk);
      #1;
    end
    iv1 = 1'b0; or1 = 1'b1; iv256 = 1'b0; or256 = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      sb_step(1, ov1, ir1, od1, or1, iv1, id1, clear);
      sb_step(2, ov256, ir256, od256, or256, iv256, id256, clear);
      @(posedge clk);
      #1;
    end
    chk("w1_left", sbq[1].size(), 0);
    chk("w1_count", popped[1], pushed[1]);
    chk("w256_left", sbq[2].size(), 0);
    chk("w256_count", popped[2], pushed[2]);
    chk("w1_traffic", pushed[1] > 1000, 1'b1);
    chk("w256_traffic", pushed[2] > 1000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: payload width in bits, legal range 1..256.
REQ-002 The block SHALL have parameter RESET_VAL, default 0: value loaded into every data register on reset and on clear.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous, active-high flush.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream payload valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the stage accepts a payload this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: downstream payload valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the payload.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: downstream payload.

Function
REQ-012 An upstream transfer SHALL occur in any cycle with in_valid=1 and in_ready=1; a downstream transfer SHALL occur in any cycle with out_valid=1 and out_ready=1.
REQ-013 The block SHALL implement a three-state machine: EMPTY (no entries), ONE (main register valid), FULL (main and skid registers valid).
REQ-014 The outputs SHALL be out_valid = (state != EMPTY), in_ready = (state != FULL), and out_data = main register; all three are driven from registers only, with no combinational path from an input.
REQ-015 In EMPTY, an upstream transfer SHALL load main and go to ONE.
REQ-016 In ONE, simultaneous upstream and downstream transfers SHALL load main and stay in ONE.
REQ-017 In ONE, an upstream transfer without a downstream transfer SHALL load skid and go to FULL.
REQ-018 In ONE, a downstream transfer without an upstream transfer SHALL go to EMPTY; with neither transfer the state SHALL hold.
REQ-019 In FULL, a downstream transfer SHALL copy skid into main and go to ONE; otherwise the state SHALL hold.
REQ-020 Latency from upstream transfer to out_valid SHALL be 1 cycle, and sustained throughput SHALL be 1 payload per cycle while out_ready=1.
REQ-021 Payload order SHALL be preserved, and no payload SHALL be dropped or duplicated except by clear or reset.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-023 clear=1 SHALL take priority over every transfer: next state is EMPTY, main and skid are set to RESET_VAL, and a payload presented in the clear cycle is discarded.
REQ-024 Downstream logic SHALL treat a payload presented on out_data during a clear cycle as discarded.

Reset
REQ-025 When rst_n=0, the block SHALL immediately (asynchronously) force state=EMPTY, out_valid=0, in_ready=1, and main=skid=out_data=RESET_VAL.
REQ-026 Reset asserted mid-transfer SHALL discard all held payloads, and normal operation SHALL resume on the first rising clk edge after rst_n returns to 1.

Configuration
REQ-027 With macro PIPE_STAGE_PERF_EN defined, the block SHALL add outputs stall_cnt[31:0] and xfer_cnt[31:0].
REQ-028 With PIPE_STAGE_PERF_EN defined, stall_cnt SHALL increment each cycle with out_valid=1 and out_ready=0, and xfer_cnt SHALL increment on each downstream transfer.
REQ-029 With PIPE_STAGE_PERF_EN defined, both counters SHALL saturate at 32'hFFFF_FFFF, reset to 0 on rst_n only, and be unaffected by clear.
REQ-030 With PIPE_STAGE_PERF_EN undefined, the counter ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover streaming: out_ready=1, in_valid=1 with in_data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, out_valid continuously 1.
REQ-032 The bench SHALL cover backpressure: from ONE holding 5, out_ready=0 and in_data 6 accepted -> FULL, in_ready=0 next cycle, out_data stays 5; then out_ready=1 -> outputs 5 then 6, no loss.
REQ-033 The bench SHALL cover clear while FULL with in_valid=1 and in_data 9 -> next cycle out_valid=0, in_ready=1, out_data=RESET_VAL, and 9 never appears.
REQ-034 The bench SHALL cover asynchronous reset asserted between clock edges while FULL -> out_valid=0 and out_data=RESET_VAL before the next edge.
REQ-035 The bench SHALL cover DATA_W=1 and DATA_W=256 with random valid/ready at 50% each over 10000 cycles -> scoreboard order and count match, out_data stable whenever stalled.
REQ-036 The bench SHALL cover the counters with PIPE_STAGE_PERF_EN defined: 3 stalled cycles and 7 transfers -> stall_cnt=3, xfer_cnt=7, and both remain unchanged after clear.
